// File: rtl/vga_tile_display.sv
// Tile-map display engine: CPU-mapped 40x30 tile map, palette and status word, plus a 2-beat pixel pipeline.
// Macro TILE_PALETTE_RAM_EN enables the writable 16x24 palette; without it colours come from a fixed mapping.
module vga_tile_display #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_2000,
    parameter int          H_ACTIVE   = 640,
    parameter int          V_ACTIVE   = 480,
    parameter int          MAP_W      = 40,
    parameter int          MAP_H      = 30,
    parameter int          TILE_SHIFT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_hit,
    output logic [31:0] cpu_rdata,
    input  logic        pix_en,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b,
    output logic        frame_tick
);
    localparam int N_TILES = MAP_W * MAP_H;
    localparam int IDX_W   = $clog2(N_TILES);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t           r_state, w_state_nxt;
    logic [IDX_W-1:0] r_clear_idx, w_clear_idx_nxt;
    logic             w_busy;

    logic [7:0]  r_tile [N_TILES];
    logic [31:0] w_off;
    logic        w_tile_sel, w_pal_sel, w_stat_sel, w_wr_en;
    logic [23:0] w_pal_rd;
    logic        w_in_vblank, w_tick;
    logic [15:0] r_frame_cnt;
    logic        r_frame_tick;

    logic        w_act_p0;
    logic [31:0] w_tidx_p0;
    logic [7:0]  w_tbyte_p0;
    logic        r_vld_p1, r_act_p1;
    logic [7:0]  r_tile_p1;
    logic [23:0] w_colour_p1, r_rgb_p2;
    logic        w_unused;

`ifndef TILE_PALETTE_RAM_EN
    function automatic logic [23:0] fixed_colour(input logic [3:0] ci);
        logic [7:0] lvl;
        lvl = ci[3] ? 8'hFF : 8'h80;
        return {ci[2] ? lvl : 8'h00, ci[1] ? lvl : 8'h00, ci[0] ? lvl : 8'h00};
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= CLEAR;
            r_clear_idx <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_clear_idx <= w_clear_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_clear_idx_nxt = r_clear_idx;
        if (r_state == CLEAR) begin
            if (r_clear_idx == IDX_W'(N_TILES - 1)) begin
                w_state_nxt     = RUN;
                w_clear_idx_nxt = '0;
            end else begin
                w_clear_idx_nxt = r_clear_idx + 1'b1;
            end
        end
    end

    assign w_busy = (r_state == CLEAR);

    // Unsigned subtraction makes addresses below the base wrap high and miss.
    assign w_off      = cpu_addr - BASE_ADDR;
    assign cpu_hit    = (w_off < 32'h0000_2000);
    assign w_tile_sel = cpu_hit && (w_off < 32'(4 * N_TILES));
    assign w_pal_sel  = cpu_hit && (w_off[12:6] == 7'h50);
    assign w_stat_sel = cpu_hit && (w_off[12:2] == 11'h600);
    assign w_wr_en    = cpu_we && !w_busy && !reset;

    always_ff @(posedge clk) begin
        if (w_busy)
            r_tile[r_clear_idx] <= 8'h00;
        else if (w_wr_en && w_tile_sel)
            r_tile[w_off[IDX_W+1:2]] <= cpu_wdata[7:0];
    end

`ifdef TILE_PALETTE_RAM_EN
    logic [23:0] r_pal [16];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j < 16; j++)
                r_pal[j] <= {3{8'(8'h11 * j)}};
        end else if (w_wr_en && w_pal_sel) begin
            r_pal[w_off[5:2]] <= cpu_wdata[23:0];
        end
    end

    assign w_pal_rd    = r_pal[w_off[5:2]];
    assign w_colour_p1 = r_pal[r_tile_p1[3:0]];
`else
    assign w_pal_rd    = '0;
    assign w_colour_p1 = fixed_colour(r_tile_p1[3:0]);
`endif

    assign w_in_vblank = (vcount >= 10'(V_ACTIVE));

    always_comb begin
        cpu_rdata = '0;
        if (w_tile_sel)
            cpu_rdata = {24'h0, r_tile[w_off[IDX_W+1:2]]};
        else if (w_pal_sel)
            cpu_rdata = {8'h0, w_pal_rd};
        else if (w_stat_sel)
            cpu_rdata = {r_frame_cnt, 14'h0, w_in_vblank, w_busy};
    end

    assign w_tick = pix_en && (hcount == 10'd0) && (vcount == 10'(V_ACTIVE));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_tick <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            r_frame_tick <= w_tick;
            if (w_tick)
                r_frame_cnt <= r_frame_cnt + 1'b1;
        end
    end

    assign frame_tick = r_frame_tick;

    // S0: coordinate -> tile index and tile byte
    assign w_act_p0   = (hcount < 10'(H_ACTIVE)) && (vcount < 10'(V_ACTIVE));
    assign w_tidx_p0  = (32'(vcount) >> TILE_SHIFT) * 32'(MAP_W) + (32'(hcount) >> TILE_SHIFT);
    assign w_tbyte_p0 = (w_tidx_p0 < 32'(N_TILES)) ? r_tile[w_tidx_p0[IDX_W-1:0]] : 8'h00;

    // S1: capture tile byte so later CPU writes cannot disturb an in-flight pixel
    always_ff @(posedge clk) begin
        if (reset)
            r_vld_p1 <= 1'b0;
        else if (pix_en)
            r_vld_p1 <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (pix_en) begin
            r_act_p1  <= w_act_p0;
            r_tile_p1 <= w_tbyte_p0;
        end
    end

    // S2: colour lookup, blanked outside the visible area and while clearing
    always_ff @(posedge clk) begin
        if (reset)
            r_rgb_p2 <= '0;
        else if (pix_en)
            r_rgb_p2 <= (r_vld_p1 && r_act_p1 && !w_busy) ? w_colour_p1 : 24'h0;
    end

    assign {r, g, b} = r_rgb_p2;

    assign w_unused = ^{cpu_wdata[31:8], w_off[31:13], w_off[1:0], r_tile_p1[7:4]};

endmodule

// File: tb/tb_vga_tile_display.sv
// Scoreboard bench for vga_tile_display: a screen-level model predicts pixel colours, register reads and frame ticks.
// Honours TILE_PALETTE_RAM_EN the same way as the design.
module tb_vga_tile_display;
    localparam logic [31:0] BASE = 32'h0000_2000;
    localparam logic [31:0] ST   = BASE + 32'h1800;

    logic        clk = 1'b0, reset = 1'b1, cpu_we = 1'b0, pix_en = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0, cpu_rdata;
    logic        cpu_hit, frame_tick;
    logic [9:0]  hcount = '0, vcount = '0;
    logic [7:0]  r, g, b;

    always #5 clk = ~clk;

    vga_tile_display dut (
        .clk(clk), .reset(reset), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_hit(cpu_hit), .cpu_rdata(cpu_rdata), .pix_en(pix_en), .hcount(hcount), .vcount(vcount),
        .r(r), .g(g), .b(b), .frame_tick(frame_tick)
    );

    int          n_vec = 0, n_err = 0;
    logic [7:0]  tile_m [1200];
    logic [23:0] pal_m [16];
    logic [15:0] fc_m = '0;
    int          clear_cnt = 0;
    logic [23:0] exp_q [$];
    logic [23:0] last_exp = '0;
    logic        ft_exp = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    function automatic bit busy_m();
        return clear_cnt < 1200;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 1200; i++) tile_m[i] = 8'h00;
        for (int j = 0; j < 16; j++) pal_m[j] = {3{8'(17 * j)}};
        fc_m = '0;
        clear_cnt = 0;
    endtask

    function automatic logic [23:0] colour_of(input logic [3:0] ci);
`ifdef TILE_PALETTE_RAM_EN
        return pal_m[ci];
`else
        logic [7:0] lvl;
        lvl = ci[3] ? 8'hFF : 8'h80;
        return {ci[2] ? lvl : 8'h00, ci[1] ? lvl : 8'h00, ci[0] ? lvl : 8'h00};
`endif
    endfunction

    function automatic logic [23:0] pix_model(input int hc, input int vc);
        logic [7:0] t;
        if (hc >= 640 || vc >= 480) return 24'h0;
        t = tile_m[(vc / 16) * 40 + hc / 16];
        return colour_of(t[3:0]);
    endfunction

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        if (off >= 32'h2000) return 32'h0;
        if (off < 32'd4800) return {24'h0, tile_m[int'(off >> 2)]};
        if (off >= 32'h1400 && off < 32'h1440) begin
`ifdef TILE_PALETTE_RAM_EN
            return {8'h0, pal_m[int'((off - 32'h1400) >> 2)]};
`else
            return 32'h0;
`endif
        end
        if ((off >> 2) == 32'h600) return {fc_m, 14'h0, vcount >= 10'd480, busy_m()};
        return 32'h0;
    endfunction

    task automatic apply_write(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] off;
        off = a - BASE;
        if (off < 32'd4800) tile_m[int'(off >> 2)] = d[7:0];
`ifdef TILE_PALETTE_RAM_EN
        else if (off >= 32'h1400 && off < 32'h1440) pal_m[int'((off - 32'h1400) >> 2)] = d[23:0];
`endif
    endtask

    // One clock of stimulus; optional combinational read check before the write lands.
    task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d,
                         input logic pe, input int hc, input int vc, input bit ck);
        @(negedge clk);
        cpu_we = we; cpu_addr = a; cpu_wdata = d; pix_en = pe;
        hcount = 10'(hc); vcount = 10'(vc);
        if (pe && !reset) exp_q.push_back(busy_m() ? 24'h0 : pix_model(hc, vc));
        #1;
        if (ck) begin
            chk("cpu_hit", 32'(cpu_hit), 32'((a - BASE) < 32'h2000));
            chk("cpu_rdata", cpu_rdata, rd_model(a));
        end
        if (we && !reset && !busy_m()) apply_write(a, d);
    endtask

    // Monitor: each pixel beat retires the pixel issued one beat earlier.
    initial begin
        logic s_rst, s_pe;
        logic [9:0] s_h, s_v;
        forever begin
            @(posedge clk);
            s_rst = reset; s_pe = pix_en; s_h = hcount; s_v = vcount;
            #1;
            if (s_rst) begin
                model_reset();
                exp_q.delete();
                last_exp = '0;
                ft_exp = 1'b0;
            end else begin
                ft_exp = s_pe && s_h == 10'd0 && s_v == 10'd480;
                if (ft_exp) fc_m++;
                if (clear_cnt < 1200) clear_cnt++;
                if (s_pe && exp_q.size() >= 2) last_exp = exp_q.pop_front();
            end
            chk("frame_tick", 32'(frame_tick), 32'(ft_exp));
            chk("rgb", 32'({r, g, b}), 32'(last_exp));
        end
    end

    initial begin
        #5ms;
        $display("FAIL timeout: got no finish, expected finish before 5ms");
        $fatal(1, "timeout");
    end

    initial begin
        int guard;
        model_reset();
        reset = 1'b1;
        repeat (3) drive(0, ST, 0, 0, 0, 0, 1);
        reset = 1'b0;

        // Clear sweep with status polling, ignored write and pixels forced dark
        for (int n = 0; n < 1210; n++) begin
            if (n == 500)
                drive(1, BASE + 32'd12, 32'h77, 0, 700, 0, 1);
            else if (n >= 10 && n < 26)
                drive(0, BASE + 32'h1400 + 32'(4 * (n - 10)), 0, 0, 0, 0, 1);
            else if (n >= 100 && n < 1000)
                drive(0, ST, 0, 1, $urandom_range(0, 700), $urandom_range(0, 520), 1);
            else if (n == 1000)
                drive(0, ST, 0, 1, 700, 0, 1);
            else
                drive(0, ST, 0, 0, 0, 0, 1);
        end
        drive(0, BASE + 32'd12, 0, 0, 0, 0, 1);

        // Register map
        drive(1, BASE + 32'd4, 32'h05, 0, 0, 0, 1);
        drive(0, BASE + 32'd4, 0, 0, 0, 0, 1);
        drive(0, BASE + 32'd7, 0, 0, 0, 0, 1);
        drive(1, BASE + 32'h12C0, 32'hFF, 0, 0, 0, 1);
        drive(0, BASE + 32'h12C0, 0, 0, 0, 0, 1);
        drive(0, BASE - 32'd4, 0, 0, 0, 0, 1);
        drive(0, BASE + 32'h2000, 0, 0, 0, 0, 1);
        drive(0, BASE + 32'h1FFC, 0, 0, 0, 0, 1);
        drive(0, BASE + 32'h1804, 0, 0, 0, 0, 1);
        drive(1, ST, 32'hFFFF_FFFF, 0, 0, 0, 1);
        drive(0, ST, 0, 0, 0, 0, 1);
        drive(1, BASE + 32'h1414, 32'hAB12_3456, 0, 0, 0, 1);
        drive(0, BASE + 32'h1414, 0, 0, 0, 0, 1);

        // Pixel path: steady, off-screen, gated beats, in-flight write
        repeat (4) drive(0, ST, 0, 1, 16, 0, 0);
        drive(0, ST, 0, 1, 700, 0, 0);
        drive(0, ST, 0, 1, 16, 0, 0);
        drive(0, ST, 0, 0, 16, 0, 0);
        drive(0, ST, 0, 0, 16, 0, 0);
        drive(0, ST, 0, 1, 16, 0, 0);
        drive(0, ST, 0, 1, 700, 0, 0);
        drive(1, BASE + 32'd8, 32'h0C, 0, 0, 0, 1);
        drive(1, BASE + 32'd12, 32'h03, 0, 0, 0, 1);
        drive(0, ST, 0, 1, 32, 0, 0);
        drive(0, ST, 0, 1, 48, 15, 0);
        drive(1, BASE + 32'd4, 32'h0A, 1, 16, 0, 1);
        drive(0, ST, 0, 1, 16, 5, 0);
        drive(0, ST, 0, 1, 700, 0, 0);

        // Randomised traffic: tile writes, window reads, pixels, occasional frame ticks
        for (int n = 0; n < 2000; n++) begin
            int kind, hc, vc;
            logic pe;
            kind = int'($urandom % 8);
            pe = ($urandom % 4) != 0;
            hc = $urandom_range(0, 700);
            vc = ($urandom % 2) ? $urandom_range(0, 40) : $urandom_range(0, 520);
            if ($urandom % 16 == 0) begin hc = 0; vc = 480; end
            if (kind < 3)
                drive(1, BASE + 32'(4 * $urandom_range(0, 79)), $urandom, pe, hc, vc, 1);
            else if (kind == 3)
                drive(1, ST, $urandom, pe, hc, vc, 1);
            else
                drive(0, BASE - 32'd32 + 32'($urandom_range(0, 8255)), 0, pe, hc, vc, 1);
        end
        drive(0, ST, 0, 1, 700, 0, 0);

        // Frame counter: single tick, no tick off column 0, then wrap
        drive(0, ST, 0, 1, 1, 480, 1);
        drive(0, ST, 0, 1, 0, 480, 1);
        drive(0, ST, 0, 0, 0, 480, 1);
        guard = 0;
        while (fc_m != 16'hFFFF && guard < 70000) begin
            drive(0, ST, 0, 1, 0, 480, 0);
            guard++;
        end
        drive(0, ST, 0, 0, 0, 480, 1);
        drive(0, ST, 0, 1, 0, 480, 1);
        drive(0, ST, 0, 0, 0, 0, 1);

        // Reset in RUN, then again mid-clear
        reset = 1'b1;
        repeat (2) drive(0, ST, 0, 0, 0, 0, 1);
        reset = 1'b0;
        repeat (300) drive(0, ST, 0, 0, 0, 0, 1);
        reset = 1'b1;
        drive(0, ST, 0, 0, 0, 0, 1);
        reset = 1'b0;
        repeat (1205) drive(0, ST, 0, 0, 0, 0, 1);
        drive(0, BASE + 32'd4, 0, 0, 0, 0, 1);
        drive(0, BASE + 32'd8, 0, 0, 0, 0, 1);
        drive(0, BASE + 32'h1414, 0, 0, 0, 0, 1);
        repeat (3) drive(0, ST, 0, 0, 0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
